// File: rtl/io_port.sv
// io_port: CPU I/O port bridging a memory-mapped DATA/STATUS pair to
// an external TX/RX word stream through two small FIFOs.
module io_port #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          iom_in,
  input  logic          wen_in,
  input  logic [15:0]   addr_in,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic [DW-1:0] tx_data_out,
  output logic          tx_valid_out,
  input  logic          tx_ready_in,
  input  logic [DW-1:0] rx_data_in,
  input  logic          rx_valid_in,
  output logic          rx_ready_out
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  // CPU access decode; only address bit 0 selects DATA (0) or STATUS (1)
  logic        cpu_wr_data;
  logic        cpu_wr_status;
  logic        cpu_rd_data;
  logic        cpu_rd_status;
  logic [14:0] unused_addr;

  assign cpu_wr_data   = iom_in & ~wen_in & ~addr_in[0];
  assign cpu_wr_status = iom_in & ~wen_in &  addr_in[0];
  assign cpu_rd_data   = iom_in &  wen_in & ~addr_in[0];
  assign cpu_rd_status = iom_in &  wen_in &  addr_in[0];
  assign unused_addr   = addr_in[15:1];

  // TX FIFO state
  logic [DW-1:0] tx_mem [DEPTH];
  logic [PW-1:0] tx_wr_ptr;
  logic [PW-1:0] tx_rd_ptr;
  logic [CW-1:0] tx_count;
  logic          tx_full;
  logic          tx_empty;
  logic          tx_push;
  logic          tx_pop;

  // RX FIFO state
  logic [DW-1:0] rx_mem [DEPTH];
  logic [PW-1:0] rx_wr_ptr;
  logic [PW-1:0] rx_rd_ptr;
  logic [CW-1:0] rx_count;
  logic          rx_full;
  logic          rx_empty;
  logic          rx_push;
  logic          rx_pop;

  logic          ovf;
  logic [4:0]    status;

  assign tx_full  = (tx_count == CW'(DEPTH));
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == CW'(DEPTH));
  assign rx_empty = (rx_count == '0);

  // Push/pop qualification uses pre-edge occupancy, so a pop never frees room for a same-cycle push
  assign tx_push = cpu_wr_data & ~tx_full;
  assign tx_pop  = tx_ready_in & ~tx_empty;
  assign rx_push = rx_valid_in & ~rx_full;
  assign rx_pop  = cpu_rd_data & ~rx_empty;

  assign tx_valid_out = ~tx_empty;
  assign tx_data_out  = tx_empty ? '0 : tx_mem[tx_rd_ptr];
  assign rx_ready_out = ~rx_full;

  assign status = {ovf, tx_full, tx_empty, rx_full, ~rx_empty};

  // CPU read mux: RX head or status word, zero when idle or writing
  always_comb begin
    data_out = '0;
    if (cpu_rd_status) begin
      data_out = DW'(status);
    end else if (cpu_rd_data && !rx_empty) begin
      data_out = rx_mem[rx_rd_ptr];
    end
  end

  // TX storage write (contents are don't-care while empty, so no reset)
  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wr_ptr] <= data_in;
    end
  end

  // RX storage write
  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem[rx_wr_ptr] <= rx_data_in;
    end
  end

  // TX pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) begin
        tx_wr_ptr <= tx_wr_ptr + PW'(1);
      end
      if (tx_pop) begin
        tx_rd_ptr <= tx_rd_ptr + PW'(1);
      end
      if (tx_push && !tx_pop) begin
        tx_count <= tx_count + CW'(1);
      end else if (!tx_push && tx_pop) begin
        tx_count <= tx_count - CW'(1);
      end
    end
  end

  // RX pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) begin
        rx_wr_ptr <= rx_wr_ptr + PW'(1);
      end
      if (rx_pop) begin
        rx_rd_ptr <= rx_rd_ptr + PW'(1);
      end
      if (rx_push && !rx_pop) begin
        rx_count <= rx_count + CW'(1);
      end else if (!rx_push && rx_pop) begin
        rx_count <= rx_count - CW'(1);
      end
    end
  end

  // Sticky overflow flag: set by a DATA write into a full TX, cleared by any STATUS write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (cpu_wr_status) begin
      ovf <= 1'b0;
    end else if (cpu_wr_data && tx_full) begin
      ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_io_port.sv
// tb_io_port: scenario tasks plus a randomized run, checked against a queue-based model.
module tb_io_port;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          iom;
  logic          wen;
  logic [15:0]   addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          txr;
  logic [DW-1:0] rxd;
  logic          rxv;
  logic          rx_ready;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: two word queues and the overflow flag
  logic [DW-1:0] tx_q[$];
  logic [DW-1:0] rx_q[$];
  logic          ovf_m;

  always #5 clk = ~clk;

  io_port #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .iom_in      (iom),
    .wen_in      (wen),
    .addr_in     (addr),
    .data_in     (din),
    .data_out    (dout),
    .tx_data_out (tx_data),
    .tx_valid_out(tx_valid),
    .tx_ready_in (txr),
    .rx_data_in  (rxd),
    .rx_valid_in (rxv),
    .rx_ready_out(rx_ready)
  );

  function automatic logic [DW-1:0] exp_dout();
    logic [4:0] s;
    if (!iom || !wen) return '0;
    if (addr[0]) begin
      s = {ovf_m, tx_q.size() == DEPTH, tx_q.size() == 0,
           rx_q.size() == DEPTH, rx_q.size() != 0};
      return DW'(s);
    end
    if (rx_q.size() == 0) return '0;
    return rx_q[0];
  endfunction

  task automatic set_in(input logic i_iom, input logic i_wen, input logic [15:0] i_addr,
                        input logic [DW-1:0] i_din, input logic i_txr,
                        input logic i_rxv, input logic [DW-1:0] i_rxd);
    iom  = i_iom;
    wen  = i_wen;
    addr = i_addr;
    din  = i_din;
    txr  = i_txr;
    rxv  = i_rxv;
    rxd  = i_rxd;
    #1;
  endtask

  // Advance the model from the currently driven inputs, then clock the DUT
  task automatic tick();
    int  tsz = tx_q.size();
    int  rsz = rx_q.size();
    bit  wr_d = iom && !wen && !addr[0];
    bit  wr_s = iom && !wen &&  addr[0];
    bit  rd_d = iom &&  wen && !addr[0];
    if (!rst_n) begin
      tx_q.delete();
      rx_q.delete();
      ovf_m = 1'b0;
    end else begin
      if (txr && tsz > 0) void'(tx_q.pop_front());
      if (wr_d && tsz < DEPTH) tx_q.push_back(din);
      if (wr_d && tsz == DEPTH) ovf_m = 1'b1;
      if (wr_s) ovf_m = 1'b0;
      if (rd_d && rsz > 0) void'(rx_q.pop_front());
      if (rxv && rsz < DEPTH) rx_q.push_back(rxd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic i_txr);
    set_in(1'b0, 1'b1, 16'h0, '0, i_txr, 1'b0, '0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    idle(1'b0);
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid got %h want 0", tx_valid); end
    n_vec++; if (tx_data !== '0) begin n_err++; $display("FAIL reset_tx_data got %h want 0", tx_data); end
    n_vec++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL reset_rx_ready got %h want 1", rx_ready); end
    n_vec++; if (dout !== '0) begin n_err++; $display("FAIL reset_data_out got %h want 0", dout); end
  endtask

  task automatic test_tx_basic();
    set_in(1'b1, 1'b0, 16'h0, 16'h1111, 1'b0, 1'b0, '0); tick();
    set_in(1'b1, 1'b0, 16'h0, 16'h2222, 1'b0, 1'b0, '0); tick();
    set_in(1'b1, 1'b1, 16'h1, '0, 1'b0, 1'b0, '0);
    n_vec++; if (tx_valid !== 1'b1) begin n_err++; $display("FAIL txb_valid got %h want 1", tx_valid); end
    n_vec++; if (tx_data !== 16'h1111) begin n_err++; $display("FAIL txb_head got %h want 1111", tx_data); end
    n_vec++; if (dout !== 16'h0000) begin n_err++; $display("FAIL txb_status got %h want 0000", dout); end
    tick();
    idle(1'b1);
    n_vec++; if (tx_data !== 16'h1111) begin n_err++; $display("FAIL txb_out0 got %h want 1111", tx_data); end
    tick();
    n_vec++; if (tx_valid !== 1'b1 || tx_data !== 16'h2222) begin n_err++; $display("FAIL txb_out1 got %h/%h want 1/2222", tx_valid, tx_data); end
    tick();
    idle(1'b0);
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL txb_drained got %h want 0", tx_valid); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 1'b0, 16'h0, DW'(16'hA0 + i), 1'b0, 1'b0, '0);
      tick();
    end
    set_in(1'b1, 1'b1, 16'h1, '0, 1'b0, 1'b0, '0);
    n_vec++; if (dout !== 16'h0018) begin n_err++; $display("FAIL ovf_status got %h want 0018", dout); end
    tick();
    set_in(1'b1, 1'b0, 16'h1, 16'hFFFF, 1'b0, 1'b0, '0); tick();
    set_in(1'b1, 1'b1, 16'h1, '0, 1'b0, 1'b0, '0);
    n_vec++; if (dout !== 16'h0008) begin n_err++; $display("FAIL ovf_cleared got %h want 0008", dout); end
    tick();
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      n_vec++; if (tx_valid !== 1'b1 || tx_data !== DW'(16'hA0 + i)) begin n_err++; $display("FAIL ovf_drain%0d got %h/%h want 1/%h", i, tx_valid, tx_data, 16'hA0 + i); end
      tick();
    end
    idle(1'b0);
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty got %h want 0", tx_valid); end
  endtask

  task automatic test_rx_read();
    set_in(1'b0, 1'b1, 16'h0, '0, 1'b0, 1'b1, 16'h0005); tick();
    set_in(1'b0, 1'b1, 16'h0, '0, 1'b0, 1'b1, 16'h0006); tick();
    set_in(1'b1, 1'b1, 16'h1, '0, 1'b0, 1'b0, '0);
    n_vec++; if (dout !== 16'h0005) begin n_err++; $display("FAIL rx_status got %h want 0005", dout); end
    tick();
    set_in(1'b1, 1'b1, 16'h0, '0, 1'b0, 1'b0, '0);
    n_vec++; if (dout !== 16'h0005) begin n_err++; $display("FAIL rx_rd0 got %h want 0005", dout); end
    tick();
    n_vec++; if (dout !== 16'h0006) begin n_err++; $display("FAIL rx_rd1 got %h want 0006", dout); end
    tick();
    n_vec++; if (dout !== 16'h0000) begin n_err++; $display("FAIL rx_rd_empty got %h want 0000", dout); end
    tick();
    set_in(1'b1, 1'b1, 16'h1, '0, 1'b0, 1'b0, '0);
    n_vec++; if (dout !== 16'h0004) begin n_err++; $display("FAIL rx_status_end got %h want 0004", dout); end
    tick();
  endtask

  task automatic test_rx_full();
    logic [DW-1:0] w [4];
    for (int i = 0; i < 4; i++) begin
      w[i] = DW'($urandom);
      set_in(1'b0, 1'b1, 16'h0, '0, 1'b0, 1'b1, w[i]);
      tick();
    end
    set_in(1'b1, 1'b1, 16'h1, '0, 1'b0, 1'b0, '0);
    n_vec++; if (rx_ready !== 1'b0) begin n_err++; $display("FAIL rxf_ready got %h want 0", rx_ready); end
    n_vec++; if (dout !== 16'h0007) begin n_err++; $display("FAIL rxf_status got %h want 0007", dout); end
    tick();
    set_in(1'b1, 1'b1, 16'h0, '0, 1'b0, 1'b1, 16'hDEAD);
    n_vec++; if (dout !== w[0]) begin n_err++; $display("FAIL rxf_pop got %h want %h", dout, w[0]); end
    tick();
    set_in(1'b1, 1'b1, 16'h1, '0, 1'b0, 1'b0, '0);
    n_vec++; if (dout !== 16'h0005) begin n_err++; $display("FAIL rxf_occ3 got %h want 0005", dout); end
    tick();
    for (int i = 1; i < 4; i++) begin
      set_in(1'b1, 1'b1, 16'h0, '0, 1'b0, 1'b0, '0);
      n_vec++; if (dout !== w[i]) begin n_err++; $display("FAIL rxf_rd%0d got %h want %h", i, dout, w[i]); end
      tick();
    end
    set_in(1'b1, 1'b1, 16'h1, '0, 1'b0, 1'b0, '0);
    n_vec++; if (dout !== 16'h0004) begin n_err++; $display("FAIL rxf_empty got %h want 0004", dout); end
    tick();
  endtask

  task automatic test_tx_full_bypass();
    logic [DW-1:0] w [4];
    for (int i = 0; i < 4; i++) begin
      w[i] = DW'($urandom);
      set_in(1'b1, 1'b0, 16'h0, w[i], 1'b0, 1'b0, '0);
      tick();
    end
    set_in(1'b1, 1'b0, 16'h0, 16'hBEEF, 1'b1, 1'b0, '0);
    n_vec++; if (tx_data !== w[0]) begin n_err++; $display("FAIL byp_head got %h want %h", tx_data, w[0]); end
    tick();
    set_in(1'b1, 1'b1, 16'h1, '0, 1'b0, 1'b0, '0);
    n_vec++; if (dout !== 16'h0010) begin n_err++; $display("FAIL byp_status got %h want 0010", dout); end
    tick();
    for (int i = 1; i < 4; i++) begin
      idle(1'b1);
      n_vec++; if (tx_valid !== 1'b1 || tx_data !== w[i]) begin n_err++; $display("FAIL byp_drain%0d got %h/%h want 1/%h", i, tx_valid, tx_data, w[i]); end
      tick();
    end
    idle(1'b0);
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL byp_empty got %h want 0", tx_valid); end
    set_in(1'b1, 1'b0, 16'h1, '0, 1'b0, 1'b0, '0); tick();
  endtask

  task automatic test_wrap();
    logic [DW-1:0] w [10];
    for (int i = 0; i < 10; i++) w[i] = DW'($urandom);
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) set_in(1'b1, 1'b0, 16'h0, w[i], 1'b1, 1'b0, '0);
      else        idle(1'b1);
      if (i > 0) begin
        n_vec++; if (tx_valid !== 1'b1 || tx_data !== w[i-1]) begin n_err++; $display("FAIL wrap_tx%0d got %h/%h want 1/%h", i - 1, tx_valid, tx_data, w[i-1]); end
      end
      tick();
    end
    for (int i = 0; i < 10; i++) w[i] = DW'($urandom);
    for (int i = 0; i <= 10; i++) begin
      set_in(i > 0, 1'b1, 16'h0, '0, 1'b0, i < 10, (i < 10) ? w[i] : '0);
      if (i > 0) begin
        n_vec++; if (dout !== w[i-1]) begin n_err++; $display("FAIL wrap_rx%0d got %h want %h", i - 1, dout, w[i-1]); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    set_in(1'b1, 1'b0, 16'h0, 16'h0101, 1'b0, 1'b1, 16'h0202); tick();
    set_in(1'b1, 1'b0, 16'h0, 16'h0303, 1'b0, 1'b1, 16'h0404); tick();
    rst_n = 1'b0;
    set_in(1'b1, 1'b0, 16'h0, 16'h0505, 1'b1, 1'b1, 16'h0606);
    tick();
    rst_n = 1'b1;
    set_in(1'b1, 1'b1, 16'h1, '0, 1'b0, 1'b0, '0);
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rstm_tx_valid got %h want 0", tx_valid); end
    n_vec++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL rstm_rx_ready got %h want 1", rx_ready); end
    n_vec++; if (dout !== 16'h0004) begin n_err++; $display("FAIL rstm_status got %h want 0004", dout); end
    tick();
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_tx;
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             16'($urandom) & 16'hFFFE | 16'($urandom_range(0, 3) == 0),
             DW'($urandom), $urandom_range(0, 2) == 0,
             $urandom_range(0, 1) == 1, DW'($urandom));
      exp_tx = (tx_q.size() != 0) ? tx_q[0] : '0;
      n_vec++; if (dout !== exp_dout()) begin n_err++; $display("FAIL rnd_dout c%0d got %h want %h", c, dout, exp_dout()); end
      n_vec++; if (tx_valid !== (tx_q.size() != 0) || tx_data !== exp_tx) begin n_err++; $display("FAIL rnd_tx c%0d got %h/%h want %h/%h", c, tx_valid, tx_data, tx_q.size() != 0, exp_tx); end
      n_vec++; if (rx_ready !== (rx_q.size() < DEPTH)) begin n_err++; $display("FAIL rnd_rx_ready c%0d got %h want %h", c, rx_ready, rx_q.size() < DEPTH); end
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    ovf_m = 1'b0;
    rst_n = 1'b0;
    idle(1'b0);
    test_reset();
    test_tx_basic();
    test_overflow();
    test_rx_read();
    test_rx_full();
    test_tx_full_bypass();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
